// File: rtl/spi_mem_writer_pkg.sv
// Shared widths, command layout and FSM encoding for the SPI register-file bridge.
package spi_mem_writer_pkg;

  localparam int MEM_ADDR_WIDTH = 3;
  localparam int DATA_BUS_WIDTH = 16;
  localparam int CMD_WR_BIT     = 7;
  localparam int CMD_LEN        = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    DATA    = 3'd2,
    COMMIT  = 3'd3,
    WAIT_CS = 3'd4
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_mem_writer.sv
// SPI mode-0 slave that turns 24-bit frames into register-file writes/reads.
// Readback over MISO is compiled in only when SPI_READBACK_EN is defined.
module spi_mem_writer
  import spi_mem_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DATA_BUS_WIDTH,
  parameter int NUM_REGS   = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SPI_SCK,
  input  logic                  SPI_CS_N,
  input  logic                  SPI_MOSI,
  output logic                  SPI_MISO,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA,
  output logic                  MEM_CLK,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  output logic                  BUSY,
  output logic                  ERROR
);

  localparam int CNT_MAX = (DATA_WIDTH > CMD_LEN) ? DATA_WIDTH : CMD_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0]    CMD_LAST   = CNT_W'(CMD_LEN - 1);
  localparam logic [CNT_W-1:0]    DATA_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

  logic sckRise, sckFall, unusedSckLevel;
  logic csLevel, csRise, csFall;

  spi_sync_edge #(.RESET_VAL(1'b0)) sckSync (
    .clk_i  (CLK),
    .rst_i  (RST),
    .async_i(SPI_SCK),
    .sync_o (unusedSckLevel),
    .rise_o (sckRise),
    .fall_o (sckFall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) csSync (
    .clk_i  (CLK),
    .rst_i  (RST),
    .async_i(SPI_CS_N),
    .sync_o (csLevel),
    .rise_o (csRise),
    .fall_o (csFall)
  );

  logic mosiMeta_q, mosiSync_q;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        bitCnt_q, bitCnt_d;
  logic [DATA_WIDTH-1:0]   rxShift_q, rxShift_d;
  logic [DATA_WIDTH-1:0]   rxNext;
  logic                    isWrite_q, isWrite_d;
  logic [ADDR_WIDTH-1:0]   memAddr_q, memAddr_d;
  logic [DATA_WIDTH-1:0]   memWdata_q, memWdata_d;
  logic                    memClk_q, memClk_d;
  logic                    busy_q;
  logic                    error_q, error_d;
  logic                    armed_q, armed_d;
  logic [1:0]              settle_q;
  logic                    addrOk;

  assign rxNext = {rxShift_q[DATA_WIDTH-2:0], mosiSync_q};
  assign addrOk = ({1'b0, memAddr_q} < NUM_REGS_W);

`ifdef SPI_READBACK_EN
  logic capture_q, capture_d;
`endif

  // A frame may only start once CS_N has been seen high by a settled synchroniser,
  // so a reset in the middle of a host frame skips the rest of that frame.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    rxShift_d  = rxShift_q;
    isWrite_d  = isWrite_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    memClk_d   = 1'b0;
    error_d    = error_q;
    armed_d    = armed_q | (csLevel & settle_q[1]);
`ifdef SPI_READBACK_EN
    capture_d  = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        bitCnt_d = '0;
        if (csFall && armed_q) state_d = CMD;
      end
      CMD: begin
        if (sckRise) begin
          rxShift_d = rxNext;
          bitCnt_d  = bitCnt_q + 1'b1;
          if (bitCnt_q == CMD_LAST) begin
            bitCnt_d  = '0;
            isWrite_d = rxNext[CMD_WR_BIT];
            state_d   = DATA;
`ifdef SPI_READBACK_EN
            memAddr_d = rxNext[ADDR_WIDTH-1:0];
            capture_d = ~rxNext[CMD_WR_BIT];
`else
            if (rxNext[CMD_WR_BIT]) memAddr_d = rxNext[ADDR_WIDTH-1:0];
`endif
          end
        end
        if (csRise) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end
      DATA: begin
        if (sckRise) begin
          rxShift_d = rxNext;
          bitCnt_d  = bitCnt_q + 1'b1;
          if (bitCnt_q == DATA_LAST) begin
            bitCnt_d = '0;
            if (isWrite_q) begin
              state_d = COMMIT;
              if (addrOk) memWdata_d = rxNext;
            end else begin
              state_d = WAIT_CS;
            end
          end
        end
        // The final SCK rise wins over a coincident CS_N rise.
        if (csRise && !(sckRise && bitCnt_q == DATA_LAST)) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end
      COMMIT: begin
        if (addrOk) memClk_d = 1'b1;
        else        error_d  = 1'b1;
        state_d = WAIT_CS;
      end
      WAIT_CS: begin
        if (csLevel) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef SPI_READBACK_EN
    if (capture_q && !addrOk) error_d = 1'b1;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mosiMeta_q <= 1'b0;
      mosiSync_q <= 1'b0;
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      rxShift_q  <= '0;
      isWrite_q  <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      memClk_q   <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      armed_q    <= 1'b0;
      settle_q   <= 2'b00;
    end else begin
      mosiMeta_q <= SPI_MOSI;
      mosiSync_q <= mosiMeta_q;
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      rxShift_q  <= rxShift_d;
      isWrite_q  <= isWrite_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      memClk_q   <= memClk_d;
      busy_q     <= (state_d != IDLE);
      error_q    <= error_d;
      armed_q    <= armed_d;
      settle_q   <= {settle_q[0], 1'b1};
    end
  end

`ifdef SPI_READBACK_EN
  logic [DATA_WIDTH-1:0] txShift_q, txShift_d;
  logic                  miso_q, miso_d;

  // Read word is captured one cycle after the address settles; MISO then
  // advances on every SCK fall while the data phase is running.
  always_comb begin
    txShift_d = txShift_q;
    miso_d    = miso_q;
    if (capture_q) begin
      txShift_d = addrOk ? MEM_RDATA : '0;
    end else if (state_q == DATA && sckFall) begin
      miso_d    = txShift_q[DATA_WIDTH-1];
      txShift_d = {txShift_q[DATA_WIDTH-2:0], 1'b0};
    end else if (state_q == IDLE) begin
      miso_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      capture_q <= 1'b0;
      txShift_q <= '0;
      miso_q    <= 1'b0;
    end else begin
      capture_q <= capture_d;
      txShift_q <= txShift_d;
      miso_q    <= miso_d;
    end
  end

  assign SPI_MISO = miso_q;
`else
  logic unusedRead;
  assign unusedRead = ^{MEM_RDATA, sckFall};
  assign SPI_MISO   = 1'b0;
`endif

  assign MEM_CLK   = memClk_q;
  assign MEM_ADDR  = memAddr_q;
  assign MEM_WDATA = memWdata_q;
  assign BUSY      = busy_q;
  assign ERROR     = error_q;

endmodule
